// File: rtl/mult_pipe_if.sv
// Issue -> multiplier -> writeback signal bundle.
// The master side is issue plus writeback; the slave side is the multiplier.
interface mult_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic             iss_mul_oper;
    logic [WIDTH-1:0] iss_mul_rega;
    logic [WIDTH-1:0] iss_mul_regb;
    logic [TAG_W-1:0] iss_mul_regdest;
    logic             iss_mul_signed;
    logic             iss_mul_high;
    logic             iss_mul_flush;
    logic             wb_mul_stall;
    logic             mul_iss_stall;
    logic             mul_wb_oper;
    logic [TAG_W-1:0] mul_wb_regdest;
    logic             mul_wb_writereg;
    logic [WIDTH-1:0] mul_wb_wbvalue;
    logic             mul_wb_overflow;

    modport master (
        output iss_mul_oper, iss_mul_rega, iss_mul_regb, iss_mul_regdest,
        output iss_mul_signed, iss_mul_high, iss_mul_flush, wb_mul_stall,
        input  mul_iss_stall, mul_wb_oper, mul_wb_regdest, mul_wb_writereg,
        input  mul_wb_wbvalue, mul_wb_overflow
    );

    modport slave (
        input  iss_mul_oper, iss_mul_rega, iss_mul_regb, iss_mul_regdest,
        input  iss_mul_signed, iss_mul_high, iss_mul_flush, wb_mul_stall,
        output mul_iss_stall, mul_wb_oper, mul_wb_regdest, mul_wb_writereg,
        output mul_wb_wbvalue, mul_wb_overflow
    );
endinterface

// File: rtl/mult_pipe.sv
// Fully pipelined signed/unsigned multiplier with a fixed STAGES-cycle latency.
// The design includes stall, flush and low/high result selection.
module mult_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 5
) (
    input logic       clock,
    input logic       reset,
    mult_pipe_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    // Stages ahead of the output register; a dummy single entry is kept when STAGES == 1.
    localparam int NI = (STAGES > 1) ? STAGES - 1 : 1;

    logic             w_accept;
    logic [PW-1:0]    w_aExt;
    logic [PW-1:0]    w_bExt;
    logic [PW-1:0]    w_inPartial;
    logic [WIDTH-1:0] w_inCross;

    logic             w_srcValid;
    logic [TAG_W-1:0] w_srcTag;
    logic             w_srcSigned;
    logic             w_srcHigh;
    logic [PW-1:0]    w_srcProd;
    logic [WIDTH-1:0] w_srcHi;
    logic [WIDTH-1:0] w_srcLo;
    logic             w_srcOverflow;

    logic             r_valid   [NI];
    logic [TAG_W-1:0] r_tag     [NI];
    logic             r_signed  [NI];
    logic             r_high    [NI];
    logic [PW-1:0]    r_partial [NI];
    logic [WIDTH-1:0] r_cross   [NI];

    logic             r_oper;
    logic [TAG_W-1:0] r_regdest;
    logic             r_writereg;
    logic [WIDTH-1:0] r_wbvalue;
    logic             r_overflow;

    assign w_accept = bus.iss_mul_oper & ~bus.wb_mul_stall & ~bus.iss_mul_flush;

    // The product is split as A*B_low plus (A*B_high)<<WIDTH.
    // Only the low WIDTH bits of the cross term survive the shift.
    always_comb begin
        w_aExt      = {{WIDTH{bus.iss_mul_signed & bus.iss_mul_rega[WIDTH-1]}}, bus.iss_mul_rega};
        w_bExt      = {{WIDTH{bus.iss_mul_signed & bus.iss_mul_regb[WIDTH-1]}}, bus.iss_mul_regb};
        w_inPartial = w_aExt * {{WIDTH{1'b0}}, w_bExt[WIDTH-1:0]};
        w_inCross   = bus.iss_mul_rega * w_bExt[PW-1:WIDTH];
    end

    always_comb begin
        w_srcValid  = 1'b0;
        w_srcTag    = '0;
        w_srcSigned = 1'b0;
        w_srcHigh   = 1'b0;
        w_srcProd   = '0;
        if (STAGES == 1) begin
            w_srcValid  = w_accept;
            w_srcTag    = bus.iss_mul_regdest;
            w_srcSigned = bus.iss_mul_signed;
            w_srcHigh   = bus.iss_mul_high;
            w_srcProd   = w_inPartial + {w_inCross, {WIDTH{1'b0}}};
        end else begin
            w_srcValid  = r_valid[NI-1];
            w_srcTag    = r_tag[NI-1];
            w_srcSigned = r_signed[NI-1];
            w_srcHigh   = r_high[NI-1];
            w_srcProd   = r_partial[NI-1] + {r_cross[NI-1], {WIDTH{1'b0}}};
        end
        w_srcHi = w_srcProd[PW-1:WIDTH];
        w_srcLo = w_srcProd[WIDTH-1:0];
        if (w_srcHigh) begin
            w_srcOverflow = 1'b0;
        end else if (w_srcSigned) begin
            w_srcOverflow = (w_srcHi != {WIDTH{w_srcLo[WIDTH-1]}});
        end else begin
            w_srcOverflow = (w_srcHi != {WIDTH{1'b0}});
        end
    end

    // The priority order is reset, then flush, then stall.
    // Each later stage folds in the cross term, which then reads as zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NI; k++) begin
                r_valid[k]   <= 1'b0;
                r_tag[k]     <= '0;
                r_signed[k]  <= 1'b0;
                r_high[k]    <= 1'b0;
                r_partial[k] <= '0;
                r_cross[k]   <= '0;
            end
            r_oper     <= 1'b0;
            r_regdest  <= '0;
            r_writereg <= 1'b0;
            r_wbvalue  <= '0;
            r_overflow <= 1'b0;
        end else if (bus.iss_mul_flush) begin
            for (int k = 0; k < NI; k++) begin
                r_valid[k] <= 1'b0;
            end
            r_oper     <= 1'b0;
            r_writereg <= 1'b0;
            r_overflow <= 1'b0;
        end else if (!bus.wb_mul_stall) begin
            r_valid[0]   <= w_accept;
            r_tag[0]     <= bus.iss_mul_regdest;
            r_signed[0]  <= bus.iss_mul_signed;
            r_high[0]    <= bus.iss_mul_high;
            r_partial[0] <= w_inPartial;
            r_cross[0]   <= w_inCross;
            for (int k = 1; k < NI; k++) begin
                r_valid[k]   <= r_valid[k-1];
                r_tag[k]     <= r_tag[k-1];
                r_signed[k]  <= r_signed[k-1];
                r_high[k]    <= r_high[k-1];
                r_partial[k] <= r_partial[k-1] + {r_cross[k-1], {WIDTH{1'b0}}};
                r_cross[k]   <= '0;
            end
            r_oper     <= w_srcValid;
            r_regdest  <= w_srcTag;
            r_writereg <= w_srcValid & (w_srcTag != '0);
            r_wbvalue  <= w_srcHigh ? w_srcHi : w_srcLo;
            r_overflow <= w_srcValid & w_srcOverflow;
        end
    end

    assign bus.mul_iss_stall   = bus.wb_mul_stall;
    assign bus.mul_wb_oper     = r_oper;
    assign bus.mul_wb_regdest  = r_regdest;
    assign bus.mul_wb_writereg = r_writereg;
    assign bus.mul_wb_wbvalue  = r_wbvalue;
    assign bus.mul_wb_overflow = r_overflow;
endmodule

// File: tb/tb_mult_pipe.sv
// Scoreboard bench for mult_pipe (WIDTH=32, STAGES=3, TAG_W=5).
// Directed vectors push hand-computed results; a negedge monitor pops and checks them.
module tb_mult_pipe;
    localparam int WIDTH  = 32;
    localparam int STAGES = 3;
    localparam int TAG_W  = 5;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] value;
        logic             ovf;
        logic             wr;
        int               due;
    } expect_t;

    logic    clock = 1'b0;
    logic    reset = 1'b1;
    int      cyc = 0;
    int      checks = 0;
    int      errors = 0;
    bit      headSeen = 1'b0;
    expect_t scoreboard[$];

    mult_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    mult_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        bus.iss_mul_oper  = 1'b0;
        bus.iss_mul_flush = 1'b0;
        repeat (n) stepCycle();
    endtask

    task automatic clearScoreboard();
        scoreboard.delete();
        headSeen = 1'b0;
    endtask

    // One accepted issue; the expected writeback is queued with its due cycle.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic sgn, input logic high, input logic [TAG_W-1:0] tag,
                                 input logic [WIDTH-1:0] expVal, input logic expOv);
        expect_t e;
        bus.iss_mul_oper    = 1'b1;
        bus.iss_mul_rega    = a;
        bus.iss_mul_regb    = b;
        bus.iss_mul_signed  = sgn;
        bus.iss_mul_high    = high;
        bus.iss_mul_regdest = tag;
        e.tag   = tag;
        e.value = expVal;
        e.ovf   = expOv;
        e.wr    = (tag != '0);
        e.due   = cyc + STAGES;
        scoreboard.push_back(e);
        stepCycle();
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (scoreboard.size() != 0 && n < budget) begin
            stepCycle();
            n++;
        end
        if (scoreboard.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d results outstanding after %0d cycles", scoreboard.size(), budget);
            clearScoreboard();
        end
    endtask

    // Results are consumed on cycles where writeback is not stalling.
    always @(negedge clock) begin
        expect_t head;
        if (!reset) begin
            if (!bus.mul_wb_oper) begin
                checkOutput("writereg_idle", 64'(bus.mul_wb_writereg), 64'(0));
            end else if (scoreboard.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_result: got tag %0d value 0x%0h, expected no result",
                         bus.mul_wb_regdest, bus.mul_wb_wbvalue);
            end else begin
                head = scoreboard[0];
                if (!headSeen) begin
                    checkOutput("latency", 64'(cyc), 64'(head.due));
                    headSeen = 1'b1;
                end
                if (!bus.wb_mul_stall) begin
                    void'(scoreboard.pop_front());
                    headSeen = 1'b0;
                    checkOutput("wbvalue", 64'(bus.mul_wb_wbvalue), 64'(head.value));
                    checkOutput("overflow", 64'(bus.mul_wb_overflow), 64'(head.ovf));
                    checkOutput("regdest", 64'(bus.mul_wb_regdest), 64'(head.tag));
                    checkOutput("writereg", 64'(bus.mul_wb_writereg), 64'(head.wr));
                end
            end
        end
    end

    initial begin
        bus.iss_mul_oper    = 1'b0;
        bus.iss_mul_rega    = '0;
        bus.iss_mul_regb    = '0;
        bus.iss_mul_regdest = '0;
        bus.iss_mul_signed  = 1'b0;
        bus.iss_mul_high    = 1'b0;
        bus.iss_mul_flush   = 1'b0;
        bus.wb_mul_stall    = 1'b0;
        repeat (2) stepCycle();
        @(negedge clock);
        checkOutput("reset_oper", 64'(bus.mul_wb_oper), 64'(0));
        checkOutput("reset_writereg", 64'(bus.mul_wb_writereg), 64'(0));
        checkOutput("reset_wbvalue", 64'(bus.mul_wb_wbvalue), 64'(0));
        checkOutput("reset_regdest", 64'(bus.mul_wb_regdest), 64'(0));
        checkOutput("reset_overflow", 64'(bus.mul_wb_overflow), 64'(0));
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(2);

        $display("[TB] signed/unsigned, low/high");
        applyStimulus(32'h00000002, 32'hFFFFFFFD, 1'b1, 1'b0, 5'd7, 32'hFFFFFFFA, 1'b0);
        applyStimulus(32'h00000002, 32'hFFFFFFFD, 1'b1, 1'b1, 5'd7, 32'hFFFFFFFF, 1'b0);
        applyStimulus(32'h00000002, 32'hFFFFFFFD, 1'b0, 1'b0, 5'd7, 32'hFFFFFFFA, 1'b1);
        applyStimulus(32'h00000002, 32'hFFFFFFFD, 1'b0, 1'b1, 5'd7, 32'h00000001, 1'b0);
        idle(1);
        waitDrain(20);

        $display("[TB] back-to-back issues");
        applyStimulus(32'd3, 32'd5, 1'b0, 1'b0, 5'd1, 32'd15, 1'b0);
        applyStimulus(32'h00010000, 32'h00010000, 1'b0, 1'b0, 5'd2, 32'h00000000, 1'b1);
        applyStimulus(32'h7FFFFFFF, 32'h00000002, 1'b1, 1'b0, 5'd3, 32'hFFFFFFFE, 1'b1);
        applyStimulus(32'h7FFFFFFF, 32'h00000002, 1'b1, 1'b1, 5'd4, 32'h00000000, 1'b0);
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 5'd5, 32'h00000001, 1'b0);
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 5'd6, 32'h00000000, 1'b0);
        applyStimulus(32'h80000000, 32'h80000000, 1'b1, 1'b0, 5'd8, 32'h00000000, 1'b1);
        applyStimulus(32'h80000000, 32'h80000000, 1'b1, 1'b1, 5'd9, 32'h40000000, 1'b0);
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 5'd30, 32'h00000001, 1'b1);
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 5'd31, 32'hFFFFFFFE, 1'b0);
        idle(1);
        waitDrain(20);

        $display("[TB] writeback stall");
        applyStimulus(32'd6, 32'd7, 1'b0, 1'b0, 5'd9, 32'd42, 1'b0);
        idle(2);
        bus.wb_mul_stall    = 1'b1;
        bus.iss_mul_oper    = 1'b1;
        bus.iss_mul_rega    = 32'd100;
        bus.iss_mul_regb    = 32'd100;
        bus.iss_mul_regdest = 5'd20;
        repeat (4) begin
            @(negedge clock);
            checkOutput("stall_oper", 64'(bus.mul_wb_oper), 64'(1));
            checkOutput("stall_value", 64'(bus.mul_wb_wbvalue), 64'(42));
            checkOutput("stall_iss", 64'(bus.mul_iss_stall), 64'(1));
            stepCycle();
        end
        bus.wb_mul_stall = 1'b0;
        bus.iss_mul_oper = 1'b0;
        @(negedge clock);
        checkOutput("stall_iss_release", 64'(bus.mul_iss_stall), 64'(0));
        stepCycle();
        @(negedge clock);
        checkOutput("stall_released", 64'(bus.mul_wb_oper), 64'(0));
        idle(4);
        waitDrain(10);

        $display("[TB] flush with ops in flight");
        applyStimulus(32'd11, 32'd12, 1'b0, 1'b0, 5'd10, 32'd132, 1'b0);
        applyStimulus(32'd13, 32'd14, 1'b0, 1'b0, 5'd11, 32'd182, 1'b0);
        bus.iss_mul_oper  = 1'b1;
        bus.iss_mul_rega  = 32'd15;
        bus.iss_mul_regb  = 32'd16;
        bus.iss_mul_flush = 1'b1;
        stepCycle();
        clearScoreboard();
        bus.iss_mul_flush = 1'b0;
        bus.iss_mul_oper  = 1'b0;
        @(negedge clock);
        checkOutput("flush_oper", 64'(bus.mul_wb_oper), 64'(0));
        idle(6);
        applyStimulus(32'd9, 32'd9, 1'b0, 1'b0, 5'd12, 32'd81, 1'b0);
        idle(1);
        waitDrain(10);

        $display("[TB] flush during stall");
        applyStimulus(32'd5, 32'd5, 1'b0, 1'b0, 5'd13, 32'd25, 1'b0);
        idle(2);
        bus.wb_mul_stall  = 1'b1;
        bus.iss_mul_flush = 1'b1;
        stepCycle();
        clearScoreboard();
        bus.wb_mul_stall  = 1'b0;
        bus.iss_mul_flush = 1'b0;
        @(negedge clock);
        checkOutput("stall_flush_oper", 64'(bus.mul_wb_oper), 64'(0));
        idle(5);

        $display("[TB] tag zero");
        applyStimulus(32'd3, 32'd4, 1'b0, 1'b0, 5'd0, 32'd12, 1'b0);
        idle(1);
        waitDrain(10);

        $display("[TB] reset with ops in flight");
        applyStimulus(32'd21, 32'd2, 1'b0, 1'b0, 5'd14, 32'd42, 1'b0);
        applyStimulus(32'd22, 32'd2, 1'b0, 1'b0, 5'd15, 32'd44, 1'b0);
        bus.iss_mul_oper = 1'b0;
        reset = 1'b1;
        stepCycle();
        clearScoreboard();
        @(negedge clock);
        checkOutput("midreset_oper", 64'(bus.mul_wb_oper), 64'(0));
        checkOutput("midreset_writereg", 64'(bus.mul_wb_writereg), 64'(0));
        checkOutput("midreset_wbvalue", 64'(bus.mul_wb_wbvalue), 64'(0));
        checkOutput("midreset_regdest", 64'(bus.mul_wb_regdest), 64'(0));
        checkOutput("midreset_overflow", 64'(bus.mul_wb_overflow), 64'(0));
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(6);
        waitDrain(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_pipe.md
# mult_pipe

Parametrised, fully pipelined integer multiplier for the issue→writeback path; successor to the single-configuration Mult unit. Accepts one operation per cycle from issue, carries the destination tag alongside, and delivers a result to writeback after a fixed STAGES-cycle latency. Supports signed/unsigned operands, low/high result-half selection, overflow detection, a writeback-driven stall and a pipeline flush.

## Interface
- WIDTH, 32, operand and result width in bits (≥2)
- STAGES, 3, pipeline depth = issue-to-result latency in cycles (≥1)
- TAG_W, 5, destination register tag width
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- iss_mul_oper  in  1  issue valid: operation presented this cycle
- iss_mul_rega  in  WIDTH  operand A
- iss_mul_regb  in  WIDTH  operand B
- iss_mul_regdest  in  TAG_W  destination register tag
- iss_mul_signed  in  1  1 = two's-complement operands; 0 = unsigned
- iss_mul_high  in  1  1 = return upper WIDTH bits of product; 0 = lower
- iss_mul_flush  in  1  discard all in-flight operations
- wb_mul_stall  in  1  writeback cannot accept; freeze pipeline
- mul_iss_stall  out  1  issue must hold; equals wb_mul_stall (combinational)
- mul_wb_oper  out  1  result valid
- mul_wb_regdest  out  TAG_W  tag of result
- mul_wb_writereg  out  1  register write enable
- mul_wb_wbvalue  out  WIDTH  selected result half
- mul_wb_overflow  out  1  product does not fit in WIDTH bits (low mode only)

## Operation
- Product is 2·WIDTH bits: operands sign-extended (signed) or zero-extended (unsigned), then multiplied.
- wbvalue = product[2W-1:W] when high=1, else product[W-1:0].
- Overflow, low mode: signed → product[2W-1:W] ≠ W copies of product[W-1]; unsigned → product[2W-1:W] ≠ 0. High mode → overflow = 0.
- Each stage holds valid, tag, signed, high and partial/complete product; final stage drives outputs directly from registers.
- Arithmetic may be split across stages freely; only the output timing and values are normative.
- mul_wb_writereg = mul_wb_oper AND (mul_wb_regdest ≠ 0); tag 0 never writes.
- Accept condition: iss_mul_oper=1, wb_mul_stall=0, iss_mul_flush=0, reset=0 at a rising edge.

## Timing
- Reset (synchronous): all valid bits, tags, data and every output register → 0; mul_wb_oper=0, writereg=0, wbvalue=0, regdest=0, overflow=0. Reset mid-operation drops all in-flight operations; no result emerges afterwards.
- Latency: operation accepted at edge N appears with mul_wb_oper=1 after edge N+STAGES-1 (STAGES cycles counting the accept cycle as cycle 1 of STAGES; for STAGES=1 output visible after the accept edge).
- Throughput: one operation per cycle; back-to-back issues produce back-to-back results in issue order.
- Stall: while wb_mul_stall=1 every stage register (including outputs) holds; valid output is held stable until the first edge with stall=0; issue input ignored.
- Bubble cycles (iss_mul_oper=0) propagate as valid=0; data registers in invalid stages are don't-care, but outputs must show writereg=0 whenever oper=0.
- Flush: at the edge with iss_mul_flush=1 all valid bits, including mul_wb_oper, clear; the operation presented that cycle is discarded. Flush has priority over stall; reset has priority over both.
- Stall and flush in the same cycle: flush wins, pipeline empties.

## Test plan
- WIDTH=32, STAGES=3: A=0x00000002, B=0xFFFFFFFD, signed=1, high=0, tag=7 → 3 cycles later oper=1, wbvalue=0xFFFFFFFA, overflow=0, writereg=1, regdest=7; same with high=1 → 0xFFFFFFFF.
- Same operands, signed=0: high=0 → 0xFFFFFFFA, overflow=1; high=1 → 0x00000001, overflow=0.
- Three consecutive issues (3×5, 0x10000×0x10000 unsigned low, 0x7FFFFFFF×2 signed low) → results 15/ov0, 0/ov1, 0xFFFFFFFE/ov1 on three consecutive cycles in order.
- Issue op, hold wb_mul_stall=1 for 4 cycles when result reaches output → oper=1 and wbvalue held constant through stall, released one cycle after stall drops; mul_iss_stall tracks stall.
- Two ops in flight, assert iss_mul_flush one cycle with a new op issued → no result ever appears; next op issued afterward returns correctly after 3 cycles.
- Issue with tag=0 → oper=1, writereg=0; assert reset with ops in flight → all outputs 0 the next cycle and no later result.
